// File: rtl/blur_job_scheduler.sv
// Round-robin job sequencer for a single image_blur engine: feeds one RGB frame
// from byte memory into the engine, waits for done, then drains the result back.
module blur_job_scheduler #(
    parameter int WIDTH   = 350,
    parameter int HEIGHT  = 350,
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 1048575
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [3:0]            req_kernel,
    input  logic [2*ADDR_W-1:0]   req_src,
    input  logic [2*ADDR_W-1:0]   req_dst,
    output logic [1:0]            ack,
    output logic                  job_err,
    output logic                  busy,
    output logic                  active_ch,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [7:0]            mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_W-1:0]     mem_wr_addr,
    output logic [7:0]            mem_wr_data,
    output logic                  blur_start,
    output logic [1:0]            blur_kernel_type,
    output logic [7:0]            blur_pixel_in,
    input  logic [7:0]            blur_pixel_out,
    input  logic                  blur_done
);
    localparam int NBYTES = WIDTH * HEIGHT * 3;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FEED, WAIT_DONE, SKIP, DRAIN, COMPLETE} state_t;
    state_t state, next_state;

    logic [CNT_W-1:0]  cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [ADDR_W-1:0] src, dst;
    logic              last_grant, err, rd_pending;
    logic              grant_ch, cnt_last, timeout_hit;

    assign cnt_last    = (cnt == CNT_W'(NBYTES - 1));
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
    // On a tie the channel that did not win last time gets the grant.
    assign grant_ch    = (req == 2'b11) ? ~last_grant : req[1];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        ack         = 2'b00;
        job_err     = 1'b0;
        busy        = (state != IDLE);
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        case (state)
            IDLE: begin
                if (|req) next_state = FEED;
            end
            FEED: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = src + ADDR_W'(cnt);
                if (cnt_last) next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (blur_done)        next_state = SKIP;
                else if (timeout_hit) next_state = COMPLETE;
            end
            SKIP: next_state = DRAIN;
            DRAIN: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = dst + ADDR_W'(cnt);
                mem_wr_data = blur_pixel_out;
                if (cnt_last) next_state = COMPLETE;
            end
            COMPLETE: begin
                ack        = active_ch ? 2'b10 : 2'b01;
                job_err    = err;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Read data lands one cycle after the strobe and is registered once more,
    // so the engine sees byte k two cycles after its read.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt              <= '0;
            to_cnt           <= '0;
            src              <= '0;
            dst              <= '0;
            last_grant       <= 1'b1;
            err              <= 1'b0;
            rd_pending       <= 1'b0;
            active_ch        <= 1'b0;
            blur_start       <= 1'b0;
            blur_kernel_type <= 2'b00;
            blur_pixel_in    <= 8'h00;
        end else begin
            rd_pending <= (state == FEED);
            if (rd_pending) blur_pixel_in <= mem_rd_data;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    to_cnt <= '0;
                    err    <= 1'b0;
                    if (|req) begin
                        active_ch        <= grant_ch;
                        last_grant       <= grant_ch;
                        blur_kernel_type <= grant_ch ? req_kernel[3:2] : req_kernel[1:0];
                        src <= grant_ch ? req_src[2*ADDR_W-1:ADDR_W] : req_src[ADDR_W-1:0];
                        dst <= grant_ch ? req_dst[2*ADDR_W-1:ADDR_W] : req_dst[ADDR_W-1:0];
                    end
                end
                FEED: begin
                    if (cnt == '0) blur_start <= 1'b1;
                    cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
                end
                WAIT_DONE: begin
                    if (blur_done) begin
                        blur_start <= 1'b0;
                    end else if (timeout_hit) begin
                        // Abandon the engine so it is not left started after an abort.
                        blur_start <= 1'b0;
                        err        <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DRAIN: cnt <= cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_blur_job_scheduler.sv
// Scoreboard bench for blur_job_scheduler with a small frame and a behavioural
// engine that raises done 10 cycles after the last byte and returns input+1.
module tb_blur_job_scheduler;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int NB = W * H * 3;
    localparam int AW = 20;

    typedef struct packed { logic [AW-1:0] addr; logic [1:0] kern; } rd_t;
    typedef struct packed { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [1:0] ack; logic err; } ack_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req;
    logic [3:0]      req_kernel;
    logic [2*AW-1:0] req_src, req_dst;
    logic [1:0]      ack;
    logic            job_err, busy, active_ch;
    logic            mem_rd_en, mem_wr_en;
    logic [AW-1:0]   mem_rd_addr, mem_wr_addr;
    logic [7:0]      mem_rd_data, mem_wr_data;
    logic            blur_start, blur_done;
    logic [1:0]      blur_kernel_type;
    logic [7:0]      blur_pixel_in, blur_pixel_out;

    int vectors     = 0;
    int miscompares = 0;
    rd_t  exp_rd[$];
    wr_t  exp_wr[$];
    ack_t exp_ack[$];

    logic       eng_no_done;
    logic [7:0] eng_buf [0:NB-1];
    int         in_cnt, dly, out_idx;
    logic       fired, start_d, gap, out_act;

    blur_job_scheduler #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .req(req), .req_kernel(req_kernel),
        .req_src(req_src), .req_dst(req_dst), .ack(ack), .job_err(job_err),
        .busy(busy), .active_ch(active_ch), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .blur_start(blur_start), .blur_kernel_type(blur_kernel_type),
        .blur_pixel_in(blur_pixel_in), .blur_pixel_out(blur_pixel_out),
        .blur_done(blur_done)
    );

    always #5 clk = ~clk;

    // Source memory content is a fixed function of address; 0x10+i holds i.
    function automatic logic [7:0] pat(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a - 20'h10;
        return t[7:0];
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= pat(mem_rd_addr);
    end

    // Engine model: byte 0 arrives the cycle after start is first seen high.
    always @(posedge clk) begin
        if (reset) begin
            in_cnt <= 0; dly <= 0; fired <= 1'b0; blur_done <= 1'b0;
            start_d <= 1'b0; gap <= 1'b0; out_act <= 1'b0; out_idx <= 0;
        end else begin
            start_d   <= blur_start;
            blur_done <= 1'b0;
            if (!blur_start) begin
                in_cnt <= 0; dly <= 0; fired <= 1'b0;
            end else if (start_d && in_cnt < NB) begin
                eng_buf[in_cnt] <= blur_pixel_in;
                in_cnt <= in_cnt + 1;
            end else if (in_cnt == NB && !fired && !eng_no_done) begin
                if (dly == 9) begin blur_done <= 1'b1; fired <= 1'b1; end
                else dly <= dly + 1;
            end
            gap <= blur_done;
            if (gap) begin
                out_act <= 1'b1; out_idx <= 0;
            end else if (out_act) begin
                if (out_idx == NB - 1) out_act <= 1'b0;
                else out_idx <= out_idx + 1;
            end
        end
    end
    assign blur_pixel_out = out_act ? eng_buf[out_idx] + 8'd1 : 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [3:0] k,
                                 input logic [2*AW-1:0] s, input logic [2*AW-1:0] d);
        req = r; req_kernel = k; req_src = s; req_dst = d;
    endtask

    task automatic pushJob(input logic ch, input logic [1:0] kern, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input int nwr, input bit with_ack, input bit err);
        rd_t r; wr_t w; ack_t a;
        for (int k = 0; k < NB; k++) begin
            r.addr = src + AW'(k); r.kern = kern;
            exp_rd.push_back(r);
        end
        for (int j = 0; j < nwr; j++) begin
            w.addr = dst + AW'(j); w.data = pat(src + AW'(j)) + 8'd1;
            exp_wr.push_back(w);
        end
        if (with_ack) begin
            a.ack = ch ? 2'b10 : 2'b01; a.err = err;
            exp_ack.push_back(a);
        end
    endtask

    task automatic waitBusy(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (busy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        checkOutput(name, 32'(busy), 1);
    endtask

    task automatic waitAck(input string name, input int bound);
        int k;
        k = 0;
        @(negedge clk);
        while (ack === 2'b00 && k < bound) begin @(negedge clk); k++; end
        checkOutput(name, 32'(ack != 2'b00), 1);
    endtask

    // Monitor: every memory strobe and ack is matched against the scoreboard.
    always @(negedge clk) begin
        rd_t er; wr_t ew; ack_t ea;
        if (mem_rd_en === 1'b1) begin
            checkOutput("rd_expected", 32'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) begin
                er = exp_rd.pop_front();
                checkOutput("rd_addr", 32'(mem_rd_addr), 32'(er.addr));
                checkOutput("kernel", 32'(blur_kernel_type), 32'(er.kern));
            end
        end
        if (mem_wr_en === 1'b1) begin
            checkOutput("wr_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
                ew = exp_wr.pop_front();
                checkOutput("wr_addr", 32'(mem_wr_addr), 32'(ew.addr));
                checkOutput("wr_data", 32'(mem_wr_data), 32'(ew.data));
            end
        end
        if (mem_rd_en === 1'b1 || mem_wr_en === 1'b1)
            checkOutput("rd_wr_exclusive", 32'(mem_rd_en & mem_wr_en), 0);
        if (ack !== 2'b00) begin
            checkOutput("ack_expected", 32'(exp_ack.size() != 0), 1);
            if (exp_ack.size() != 0) begin
                ea = exp_ack.pop_front();
                checkOutput("ack", 32'(ack), 32'(ea.ack));
                checkOutput("job_err", 32'(job_err), 32'(ea.err));
                checkOutput("busy_at_ack", 32'(busy), 1);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k, n;
        reset = 1'b1; eng_no_done = 1'b0;
        applyStimulus(2'b00, 4'h0, '0, '0);
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ack", 32'(ack), 0);
        checkOutput("rst_start", 32'(blur_start), 0);
        checkOutput("rst_rd_en", 32'(mem_rd_en), 0);
        checkOutput("rst_wr_en", 32'(mem_wr_en), 0);
        checkOutput("rst_active_ch", 32'(active_ch), 0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] round-robin with req=11 held");
        pushJob(1'b0, 2'd1, 20'h200, 20'h300, NB, 1, 0);
        pushJob(1'b1, 2'd3, 20'h400, 20'h500, NB, 1, 0);
        pushJob(1'b0, 2'd1, 20'h200, 20'h300, NB, 1, 0);
        applyStimulus(2'b11, {2'd3, 2'd1}, {20'h400, 20'h200}, {20'h500, 20'h300});
        for (int i = 0; i < 3; i++) begin
            waitAck("arb_ack_seen", 200);
            checkOutput("arb_order", 32'(ack), (i == 1) ? 32'd2 : 32'd1);
            if (i == 2) req = 2'b00;
        end
        @(negedge clk);
        checkOutput("arb_busy_after", 32'(busy), 0);

        $display("[TB] single job ch0 kernel 2");
        pushJob(1'b0, 2'd2, 20'h0, 20'd100, NB, 1, 0);
        applyStimulus(2'b01, {2'd0, 2'd2}, {20'h0, 20'h0}, {20'h0, 20'd100});
        waitBusy("t1_busy");
        req = 2'b00;
        waitAck("t1_ack_seen", 200);
        checkOutput("t1_err", 32'(job_err), 0);
        @(negedge clk);
        checkOutput("t1_busy_after", 32'(busy), 0);

        $display("[TB] start and pixel timing");
        pushJob(1'b0, 2'd0, 20'h10, 20'h40, NB, 1, 0);
        applyStimulus(2'b01, 4'h0, {20'h0, 20'h10}, {20'h0, 20'h40});
        waitBusy("tm_busy");
        req = 2'b00;
        k = 0;
        while (blur_start !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        checkOutput("start_delay", 32'(k), 1);
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            checkOutput("pixel_seq", 32'(blur_pixel_in), 32'(i));
        end
        k = 0;
        while (blur_done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        checkOutput("done_seen", 32'(blur_done), 1);
        @(negedge clk);
        checkOutput("skip_no_wr", 32'(mem_wr_en), 0);
        @(negedge clk);
        checkOutput("first_wr_at_2", 32'(mem_wr_en), 1);
        waitAck("tm_ack_seen", 200);
        @(negedge clk);

        $display("[TB] engine never done");
        eng_no_done = 1'b1;
        pushJob(1'b1, 2'd1, 20'h800, 20'h900, 0, 1, 1);
        applyStimulus(2'b10, {2'd1, 2'd0}, {20'h800, 20'h0}, {20'h900, 20'h0});
        waitBusy("to_busy");
        req = 2'b00;
        k = 0;
        while (mem_rd_en === 1'b1 && k < 100) begin @(negedge clk); k++; end
        checkOutput("feed_len", 32'(k), NB);
        n = 0;
        while (ack === 2'b00 && n < 300) begin @(negedge clk); n++; end
        checkOutput("timeout_latency", 32'(n), 100);
        checkOutput("timeout_err", 32'(job_err), 1);
        @(negedge clk);
        checkOutput("timeout_busy_after", 32'(busy), 0);
        checkOutput("timeout_err_cleared", 32'(job_err), 0);
        eng_no_done = 1'b0;

        $display("[TB] source address wrap");
        pushJob(1'b1, 2'd0, 20'hFFFFE, 20'h1000, NB, 1, 0);
        applyStimulus(2'b10, 4'h0, {20'hFFFFE, 20'h0}, {20'h1000, 20'h0});
        waitBusy("wrap_busy");
        req = 2'b00;
        waitAck("wrap_ack_seen", 200);
        @(negedge clk);

        $display("[TB] reset during drain");
        pushJob(1'b0, 2'd1, 20'h2000, 20'h3000, 6, 0, 0);
        applyStimulus(2'b01, {2'd0, 2'd1}, {20'h0, 20'h2000}, {20'h0, 20'h3000});
        waitBusy("rd_busy");
        req = 2'b00;
        k = 0; n = 0;
        while (n < 6 && k < 200) begin
            @(negedge clk); k++;
            if (mem_wr_en === 1'b1) n++;
        end
        checkOutput("drain_j5_reached", 32'(n), 6);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_wr_en", 32'(mem_wr_en), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_ack", 32'(ack), 0);
        checkOutput("abort_start", 32'(blur_start), 0);
        checkOutput("abort_pixel", 32'(blur_pixel_in), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        pushJob(1'b0, 2'd1, 20'h2000, 20'h3000, NB, 1, 0);
        applyStimulus(2'b11, {2'd2, 2'd1}, {20'h400, 20'h2000}, {20'h500, 20'h3000});
        waitBusy("post_rst_busy");
        checkOutput("post_rst_grant", 32'(active_ch), 0);
        req = 2'b00;
        waitAck("post_rst_ack_seen", 200);
        repeat (5) @(negedge clk);

        checkOutput("rd_queue_empty", 32'(exp_rd.size()), 0);
        checkOutput("wr_queue_empty", 32'(exp_wr.size()), 0);
        checkOutput("ack_queue_empty", 32'(exp_ack.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
